// File: rtl/move_collector_if.sv
// Valid/ready move stream between the collector and its consumer.
interface move_collector_if #(
  parameter int unsigned MVW = 19
) ();
  logic [MVW-1:0] mv_data;
  logic           mv_valid;
  logic           mv_ready;

  modport master (output mv_data, output mv_valid, input mv_ready);
  modport slave  (input mv_data, input mv_valid, output mv_ready);
endinterface

// File: rtl/move_collector.sv
// Scans the per-square move FIFOs in square order once every square is done,
// unpacks each popped word into its eight move slots and streams the valid
// moves out one per cycle, counting the moves the consumer accepts.
module move_collector #(
  parameter int unsigned NSQ   = 64,
  parameter int unsigned MVW   = 19,
  parameter int unsigned SLOTS = 8,
  parameter int unsigned FW    = 160,
  parameter int unsigned CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     all_done,
  input  logic [NSQ-1:0]           fifo_empty_vec,
  output logic [$clog2(NSQ)-1:0]   sq_sel,
  output logic                     rden,
  input  logic [FW-1:0]            fifo_q,
  move_collector_if.master         mv,
  output logic [CNTW-1:0]          mv_count,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned SQW   = $clog2(NSQ);
  localparam int unsigned SLW   = $clog2(SLOTS);
  localparam int unsigned WORDW = SLOTS * MVW;

  localparam logic [SQW-1:0]  SQ_LAST  = SQW'(NSQ - 1);
  localparam logic [SLW-1:0]  SLOT_TOP = SLW'(SLOTS - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE, ARM, SCAN, READ, WAIT, UNPK, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WORDW-1:0]  wrd, wrd_nxt;
  logic [SLW-1:0]    slot, slot_nxt;
  logic [MVW-1:0]    mv_data_q, mv_data_nxt;
  logic              mv_valid_q, mv_valid_nxt;
  logic [SQW-1:0]    sq_sel_nxt;
  logic [CNTW-1:0]   mv_count_nxt;
  logic              rden_nxt, busy_nxt, done_nxt;
  logic [MVW-1:0]    cur_slot;

  // Filler bits above the last slot carry no move data.
  logic unused_filler;
  assign unused_filler = ^fifo_q[FW-1:WORDW];

  assign mv.mv_data  = mv_data_q;
  assign mv.mv_valid = mv_valid_q;

  function automatic logic [MVW-1:0] slot_of(input logic [WORDW-1:0] w,
                                             input logic [SLW-1:0]   i);
    return w[MVW*i +: MVW];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (all_done) state_nxt = SCAN;
      SCAN: begin
        if (!fifo_empty_vec[sq_sel])   state_nxt = READ;
        else if (sq_sel == SQ_LAST)    state_nxt = DONE;
      end
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = UNPK;
      // Leave once slot 0 has been consumed or skipped; the FIFO may hold more.
      UNPK:    if ((!mv_valid_q || mv.mv_ready) && slot == '0) state_nxt = SCAN;
      DONE:    if (start) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the word/slot datapath.
  always_comb begin
    sq_sel_nxt   = sq_sel;
    wrd_nxt      = wrd;
    slot_nxt     = slot;
    mv_data_nxt  = mv_data_q;
    mv_valid_nxt = mv_valid_q;
    mv_count_nxt = mv_count;
    cur_slot     = '0;
    rden_nxt     = (state_nxt == READ);
    busy_nxt     = (state_nxt != IDLE) && (state_nxt != DONE);
    done_nxt     = (state_nxt == DONE);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          mv_count_nxt = '0;
          sq_sel_nxt   = '0;
        end
      end
      SCAN: begin
        if (fifo_empty_vec[sq_sel] && sq_sel != SQ_LAST)
          sq_sel_nxt = SQW'(sq_sel + 1'b1);
      end
      // Data arrives one cycle after rden; present the top slot straight away.
      WAIT: begin
        wrd_nxt      = fifo_q[WORDW-1:0];
        slot_nxt     = SLOT_TOP;
        cur_slot     = slot_of(fifo_q[WORDW-1:0], SLOT_TOP);
        mv_valid_nxt = !cur_slot[MVW-1];
        if (!cur_slot[MVW-1]) mv_data_nxt = cur_slot;
      end
      UNPK: begin
        if (mv_valid_q && mv.mv_ready && mv_count != CNT_MAX)
          mv_count_nxt = CNTW'(mv_count + 1'b1);
        if (!mv_valid_q || mv.mv_ready) begin
          if (slot == '0) begin
            mv_valid_nxt = 1'b0;
          end else begin
            slot_nxt     = SLW'(slot - 1'b1);
            cur_slot     = slot_of(wrd, SLW'(slot - 1'b1));
            mv_valid_nxt = !cur_slot[MVW-1];
            if (!cur_slot[MVW-1]) mv_data_nxt = cur_slot;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_sel     <= '0;
      rden       <= 1'b0;
      mv_data_q  <= '0;
      mv_valid_q <= 1'b0;
      mv_count   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrd        <= '0;
      slot       <= SLOT_TOP;
    end else begin
      sq_sel     <= sq_sel_nxt;
      rden       <= rden_nxt;
      mv_data_q  <= mv_data_nxt;
      mv_valid_q <= mv_valid_nxt;
      mv_count   <= mv_count_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      wrd        <= wrd_nxt;
      slot       <= slot_nxt;
    end
  end

endmodule

// File: tb/tb_move_collector.sv
// Bench for move_collector: FIFO model per square, move monitor, table of
// single-word collections plus hand sequences for multi-cycle corner cases.
module tb_move_collector;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         all_done;
  logic [63:0]  fifo_empty_vec;
  logic [5:0]   sq_sel;
  logic         rden;
  logic [159:0] fifo_q;
  logic [7:0]   mv_count;
  logic         busy;
  logic         done;

  move_collector_if #(.MVW(19)) mvif ();

  move_collector dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .all_done       (all_done),
    .fifo_empty_vec (fifo_empty_vec),
    .sq_sel         (sq_sel),
    .rden           (rden),
    .fifo_q         (fifo_q),
    .mv             (mvif),
    .mv_count       (mv_count),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Square FIFO model: non-show-ahead, data one cycle after rden.
  logic [159:0] mem [64][DEPTH];
  int           wr_ptr [64];
  int           rd_ptr [64];
  int           rd_empty_viol = 0;

  always_comb begin
    for (int k = 0; k < 64; k++) fifo_empty_vec[k] = (wr_ptr[k] == rd_ptr[k]);
  end

  always @(posedge clk) begin
    if (rden) begin
      if (wr_ptr[sq_sel] == rd_ptr[sq_sel]) rd_empty_viol <= rd_empty_viol + 1;
      fifo_q         <= mem[sq_sel][rd_ptr[sq_sel] % DEPTH];
      rd_ptr[sq_sel] <= rd_ptr[sq_sel] + 1;
    end
  end

  // Monitor: accepted moves, rden pulses, stall stability.
  logic [18:0] got_q [$];
  int          hs_cyc [$];
  int          cyc = 0;
  int          rden_cnt = 0;
  int          rden_viol = 0;
  int          rden_sq_last = -1;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic        prev_rden = 1'b0;
  logic [18:0] prev_data = '0;
  logic        mon_en;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && prev_stall && (!mvif.mv_valid || mvif.mv_data != prev_data))
      stall_viol <= stall_viol + 1;
    prev_stall = mon_en && mvif.mv_valid && !mvif.mv_ready;
    prev_data  = mvif.mv_data;
    if (mvif.mv_valid && mvif.mv_ready) begin
      got_q.push_back(mvif.mv_data);
      hs_cyc.push_back(cyc);
    end
    if (rden) begin
      rden_cnt     <= rden_cnt + 1;
      rden_sq_last <= int'(sq_sel);
      if (prev_rden) rden_viol <= rden_viol + 1;
    end
    prev_rden = rden;
  end

  logic [18:0] exp_q [$];
  int          ready_mode = 0;
  int          rp_idx = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    rp_idx++;
    if (ready_mode == 1) mvif.mv_ready = (rp_idx % 3 == 0);
    else                 mvif.mv_ready = 1'b1;
  endtask

  function automatic logic [159:0] build_word(input logic [7:0] mask, input int base);
    logic [159:0] w;
    w = '0;
    w[159:152] = 8'hA5;
    for (int i = 0; i < 8; i++)
      w[19*i +: 19] = mask[i] ? {1'b0, 18'(base + i)} : {1'b1, 18'(18'h3ff00 + i)};
    return w;
  endfunction

  task automatic load_word(input int sq, input logic [7:0] mask, input int base);
    mem[sq][wr_ptr[sq] % DEPTH] = build_word(mask, base);
    wr_ptr[sq] = wr_ptr[sq] + 1;
    for (int i = 7; i >= 0; i--)
      if (mask[i]) exp_q.push_back({1'b0, 18'(base + i)});
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < 64; k++) wr_ptr[k] = rd_ptr[k];
  endtask

  // Pulse start and wait (bounded) for done; n counts edges from the start edge.
  task automatic run(input int mode, input int timeout, output int n);
    ready_mode = mode;
    rp_idx = 0;
    mvif.mv_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < timeout) begin
      tick();
      n++;
    end
  endtask

  task automatic check_moves(input string name, input int bg, input int be);
    int ng, ne;
    ng = got_q.size() - bg;
    ne = exp_q.size() - be;
    check({name, "_nmoves"}, ng, ne);
    for (int i = 0; i < ng && i < ne; i++)
      check({name, "_move"}, got_q[bg+i], exp_q[be+i]);
  endtask

  typedef struct {
    int          sq;
    logic [7:0]  mask;
    int          base;
    int          ready_mode;
    int          exp_cnt;
    logic [18:0] exp_first;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n, bg, be, br, bs, bh;

    vecs[0] = '{sq: 12, mask: 8'h20, base: 'h30F, ready_mode: 0, exp_cnt: 1, exp_first: 19'h00314};
    vecs[1] = '{sq: 63, mask: 8'hFF, base: 'h100, ready_mode: 0, exp_cnt: 8, exp_first: 19'h00107};
    vecs[2] = '{sq: 0,  mask: 8'h00, base: 'h180, ready_mode: 0, exp_cnt: 0, exp_first: 19'h00000};
    vecs[3] = '{sq: 30, mask: 8'h81, base: 'h200, ready_mode: 1, exp_cnt: 2, exp_first: 19'h00207};
    vecs[4] = '{sq: 5,  mask: 8'h55, base: 'h300, ready_mode: 1, exp_cnt: 4, exp_first: 19'h00306};

    reset = 1'b0;
    start = 1'b0;
    all_done = 1'b0;
    mvif.mv_ready = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", rden, 0);
    check("rst_valid", mvif.mv_valid, 0);
    check("rst_data", mvif.mv_data, 0);
    check("rst_count", mv_count, 0);
    check("rst_sq_sel", sq_sel, 0);
    reset = 1'b1;
    tick();

    // All FIFOs empty: 64 scanned squares, no reads.
    all_done = 1'b1;
    br = rden_cnt;
    run(0, 200, n);
    check("empty_done", done, 1);
    check("empty_cycles", n, 66);
    check("empty_busy", busy, 0);
    check("empty_count", mv_count, 0);
    check("empty_rden", rden_cnt - br, 0);

    // Single-word collections.
    foreach (vecs[v]) begin
      bg = got_q.size();
      be = exp_q.size();
      br = rden_cnt;
      bs = stall_viol;
      load_word(vecs[v].sq, vecs[v].mask, vecs[v].base);
      run(vecs[v].ready_mode, 500, n);
      check("vec_done", done, 1);
      check("vec_count", mv_count, vecs[v].exp_cnt);
      check("vec_rden", rden_cnt - br, 1);
      check("vec_rden_sq", rden_sq_last, vecs[v].sq);
      check("vec_stall", stall_viol - bs, 0);
      if (vecs[v].exp_cnt > 0 && got_q.size() > bg)
        check("vec_first", got_q[bg], vecs[v].exp_first);
      check_moves("vec", bg, be);
    end

    // Two full words in square 0, consumer always ready.
    bg = got_q.size();
    be = exp_q.size();
    bh = hs_cyc.size();
    load_word(0, 8'hFF, 'h400);
    load_word(0, 8'hFF, 'h410);
    run(0, 500, n);
    check("two_done", done, 1);
    check("two_count", mv_count, 16);
    check_moves("two", bg, be);
    if (hs_cyc.size() >= bh + 16) begin
      check("two_burst1", hs_cyc[bh+7] - hs_cyc[bh], 7);
      check("two_burst2", hs_cyc[bh+15] - hs_cyc[bh+8], 7);
    end

    // Same two words with a stalling consumer (1,0,0,1,...).
    bg = got_q.size();
    be = exp_q.size();
    bs = stall_viol;
    load_word(0, 8'hFF, 'h400);
    load_word(0, 8'hFF, 'h410);
    run(1, 1000, n);
    check("stall_done", done, 1);
    check("stall_count", mv_count, 16);
    check("stall_hold", stall_viol - bs, 0);
    check_moves("stall", bg, be);

    // 300 moves across squares 0..40: counter saturates.
    bg = got_q.size();
    be = exp_q.size();
    for (int k = 0; k < 37; k++) load_word(k, 8'hFF, 'h1000 + 8*k);
    load_word(40, 8'h0F, 'h2000);
    run(0, 5000, n);
    check("sat_done", done, 1);
    check("sat_count", mv_count, 255);
    check("sat_total", got_q.size() - bg, 300);
    check_moves("sat", bg, be);

    // start while all_done=0 holds in ARM; start during SCAN is ignored.
    all_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("arm_busy", busy, 1);
    check("arm_done", done, 0);
    check("arm_sq_sel", sq_sel, 0);
    all_done = 1'b1;
    repeat (4) tick();
    check("scan_sq_sel", sq_sel, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("scan_ignore_start", sq_sel, 4);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("scan_remaining", n, 60);

    // Asynchronous reset while a move is pending.
    load_word(7, 8'hFF, 'h500);
    ready_mode = 1;
    rp_idx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(mvif.mv_valid && mv_count == 8'd2) && n < 200) begin
      tick();
      n++;
    end
    check("pre_rst_valid", mvif.mv_valid, 1);
    check("pre_rst_count", mv_count, 2);
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", mvif.mv_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", mv_count, 0);
    tick();
    clear_fifos();
    reset = 1'b1;
    mon_en = 1'b1;
    tick();
    run(0, 200, n);
    check("post_rst_cycles", n, 66);

    check("rden_on_empty", rd_empty_viol, 0);
    check("rden_width", rden_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
